// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART receiver
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input, FIFO read and status bundle of the UART receiver
interface uart_rx_if;

  logic       RsRx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  // Driver side: owns the serial line and the FIFO/flag controls.
  modport master (
    output RsRx, rd_en, err_clr,
    input  rx_data, rx_valid, rx_full, frame_err, overrun
  );

  // Receiver side.
  modport slave (
    input  RsRx, rd_en, err_clr,
    output rx_data, rx_valid, rx_full, frame_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through receive FIFO
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A read of an empty FIFO is ignored; a write into a full FIFO only lands
  // when a read frees the head slot in the same cycle.
  assign w_pop   = i_rd_en && !w_empty;
  assign w_push  = i_wr_en && (!w_full || w_pop);
  assign o_drop  = i_wr_en && w_full && !w_pop;

  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; the wrap bit gives modulo-DEPTH wrap for free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are masked by o_empty so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, FIFO and sticky errors
module uart_rx #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  uart_rx_if.slave bus
);

  import uart_pkg::*;

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int TW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [TW-1:0]  TICK_MAX = TW'(BAUD_DIV - 1);
  localparam logic [OSW-1:0] MID_LAST = OSW'(MID_SAMPLE - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_rx_s;
  logic [TW-1:0]        r_tick_cnt;
  logic                 w_tick;
  logic [OSW-1:0]       r_os_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic                 w_os_clr;
  logic                 w_bit_clr;
  logic                 w_shift_en;
  logic                 w_push;
  logic                 w_ferr_set;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_drop;
  logic                 r_frame_err;
  logic                 r_overrun;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.RsRx;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_MAX);

  // Free-running oversample tick divider.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes: mid-start check, then one sample every
  // OVERSAMPLE ticks for the data bits and the stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_os_clr    = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_os_clr    = 1'b1;
        end
      end
      START: begin
        if (w_tick && (r_os_cnt == MID_LAST)) begin
          w_os_clr    = 1'b1;
          w_bit_clr   = 1'b1;
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick && (r_os_cnt == OS_LAST)) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_LAST) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick && (r_os_cnt == OS_LAST)) begin
          if (r_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (r_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Oversample counter wraps naturally every OVERSAMPLE ticks after mid-start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         r_os_cnt <= '0;
    else if (w_os_clr) r_os_cnt <= '0;
    else if (w_tick)   r_os_cnt <= r_os_cnt + 1'b1;
  end

  // Bit counter and LSB-first shift register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift_en)      r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_wr_en   (w_push),
    .i_wr_data (r_shift),
    .i_rd_en   (bus.rd_en),
    .o_rd_data (bus.rx_data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_drop    (w_drop)
  );

  // Sticky error flags; a new error in the same cycle beats a clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)       r_frame_err <= 1'b1;
      else if (bus.err_clr) r_frame_err <= 1'b0;
      if (w_drop)           r_overrun   <= 1'b1;
      else if (bus.err_clr) r_overrun   <= 1'b0;
    end
  end

  assign bus.rx_valid  = !w_fifo_empty;
  assign bus.rx_full   = w_fifo_full;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a serial-line reference model
module tb_uart_rx;

  localparam int BAUD_DIV   = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 16 * BAUD_DIV;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  uart_rx_if u_if ();

  uart_rx #(
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (u_if)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         auto_rd  = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         exp_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Transmit one 8N1 frame; the model FIFO accepts a good byte only if it has room.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    u_if.RsRx = 1'b0;
    clocks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      u_if.RsRx = b[i];
      clocks(BIT_CLKS);
    end
    if (stop_bit) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
      else                           exp_ovr = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
    u_if.RsRx = stop_bit;
    clocks(BIT_CLKS);
    u_if.RsRx = 1'b1;
  endtask

  task automatic pulse_err_clr();
    u_if.err_clr = 1'b1;
    clocks(1);
    u_if.err_clr = 1'b0;
    clocks(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"},  u_if.rx_valid,  0);
    check({tag, "_rx_full"},   u_if.rx_full,   0);
    check({tag, "_rx_data"},   u_if.rx_data,   0);
    check({tag, "_frame_err"}, u_if.frame_err, 0);
    check({tag, "_overrun"},   u_if.overrun,   0);
  endtask

  // Monitor: pops the DUT FIFO whenever enabled and compares with the model queue.
  initial begin
    u_if.rd_en = 1'b0;
    forever begin
      @(negedge CLK);
      if (auto_rd && (u_if.rx_valid === 1'b1)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h expected=none", u_if.rx_data);
        end else begin
          check("rx_data", u_if.rx_data, exp_q.pop_front());
        end
        u_if.rd_en = 1'b1;
      end else begin
        u_if.rd_en = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         sb;
    u_if.RsRx    = 1'b1;
    u_if.err_clr = 1'b0;
    RESET        = 1'b1;
    clocks(3);
    check_reset_outputs("reset");
    RESET = 1'b0;
    clocks(5);

    // Single byte held in the FIFO, then drained.
    auto_rd = 1'b0;
    send_frame(8'hA5, 1'b1);
    clocks(4);
    check("a5_valid", u_if.rx_valid, 1);
    check("a5_data",  u_if.rx_data,  8'hA5);
    auto_rd = 1'b1;
    clocks(4);
    check("a5_drained", u_if.rx_valid, 0);
    check("a5_model_empty", exp_q.size(), 0);

    // Short low glitch must be rejected silently.
    u_if.RsRx = 1'b0;
    clocks(4);
    u_if.RsRx = 1'b1;
    clocks(40);
    check("glitch_valid", u_if.rx_valid,  0);
    check("glitch_ferr",  u_if.frame_err, 0);
    check("glitch_ovr",   u_if.overrun,   0);

    // Bad stop bit followed by a long break: one error only.
    send_frame(8'h3C, 1'b0);
    u_if.RsRx = 1'b0;
    clocks(200);
    check("break_ferr",  u_if.frame_err, exp_ferr);
    check("break_valid", u_if.rx_valid,  0);
    pulse_err_clr();
    exp_ferr = 1'b0;
    check("break_clr", u_if.frame_err, exp_ferr);
    clocks(100);
    check("break_single", u_if.frame_err, exp_ferr);
    u_if.RsRx = 1'b1;
    clocks(40);
    check("break_release_ferr",  u_if.frame_err, exp_ferr);
    check("break_release_valid", u_if.rx_valid,  0);

    // Overfill: fifth byte dropped, first four preserved in order.
    auto_rd = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1);
    clocks(4);
    check("ovr_full", u_if.rx_full, (exp_q.size() == FIFO_DEPTH));
    check("ovr_flag", u_if.overrun, exp_ovr);
    check("ovr_head", u_if.rx_data, exp_q[0]);
    pulse_err_clr();
    exp_ovr = 1'b0;
    check("ovr_clr", u_if.overrun, exp_ovr);
    auto_rd = 1'b1;
    clocks(10);
    check("ovr_drained", u_if.rx_valid, 0);
    check("ovr_model_empty", exp_q.size(), 0);
    check("ovr_not_full", u_if.rx_full, 0);

    // Reset in the middle of bit 3 of 0xFF, then a clean 0x12.
    u_if.RsRx = 1'b0;
    clocks(BIT_CLKS);
    u_if.RsRx = 1'b1;
    clocks(3 * BIT_CLKS + BIT_CLKS / 2);
    RESET = 1'b1;
    clocks(2);
    check_reset_outputs("midreset");
    RESET = 1'b0;
    clocks(6 * BIT_CLKS);
    send_frame(8'h12, 1'b1);
    clocks(10);
    check("midreset_model_empty", exp_q.size(), 0);
    check("midreset_valid", u_if.rx_valid,  0);
    check("midreset_ferr",  u_if.frame_err, 0);

    // Loopback-style 0x55 at matching baud.
    send_frame(8'h55, 1'b1);
    clocks(10);
    check("loop_model_empty", exp_q.size(), 0);
    check("loop_ferr", u_if.frame_err, 0);
    check("loop_ovr",  u_if.overrun,   0);

    // Random traffic with occasional bad stop bits and random idle gaps.
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      send_frame(b, sb);
      clocks($urandom_range(4, 40));
    end
    clocks(20);
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_valid", u_if.rx_valid,  0);
    check("rand_ferr",  u_if.frame_err, exp_ferr);
    check("rand_ovr",   u_if.overrun,   exp_ovr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 27, meaning system clocks per 16x-oversample tick (bit period = 16*BAUD_DIV clocks).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, >=2).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 RsRx  input  1  serial line, idle high, 8N1, LSB first.
REQ-006 rd_en  input  1  pop head of FIFO this cycle.
REQ-007 err_clr  input  1  clear sticky error flags.
REQ-008 rx_data  output  8  FIFO head byte (first-word fall-through); 0x00 when empty.
REQ-009 rx_valid  output  1  FIFO not empty.
REQ-010 rx_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 frame_err  output  1  sticky: stop bit sampled low.
REQ-012 overrun  output  1  sticky: byte dropped because FIFO full.

Function
REQ-013 RsRx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-014 Tick generator SHALL count 0..BAUD_DIV-1 and assert a one-cycle tick when count = BAUD_DIV-1, then wrap to 0; it SHALL run freely.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: on rx_s=0 -> START, with the oversample counter cleared.
REQ-017 START: at the 8th tick (mid-bit), if rx_s=0 -> DATA, else -> IDLE (glitch rejected; no flag set).
REQ-018 DATA: sample rx_s every 16 ticks after mid-start; shift LSB first; after 8 samples -> STOP.
REQ-019 STOP: sample 16 ticks after the last data bit; if 1, push byte and -> IDLE; if 0, set frame_err, discard byte, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rx_s=1, then -> IDLE; a held-low break SHALL produce exactly one frame_err.
REQ-021 A pushed byte SHALL appear on rx_data/rx_valid the cycle after the stop-sample tick.
REQ-022 rd_en with the FIFO empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Push with the FIFO full and no pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-024 Push and pop in the same cycle while full: both performed, overrun not set; while empty: push only.
REQ-025 err_clr SHALL clear frame_err and overrun the next cycle; a simultaneous set wins over clear.

Reset
REQ-026 RESET high SHALL asynchronously force: FSM=IDLE, synchronizer flops=1, tick and oversample counters=0, shift register=0, FIFO empty (rx_valid=0, rx_full=0, rx_data=0x00), frame_err=0, overrun=0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL resume at the next falling edge.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state typedef, OVERSAMPLE=16, DATA_BITS=8 and MID_SAMPLE=8.
REQ-029 FIFO SHALL be a sub-module uart_rx_fifo (parameterized by depth, 8-bit width, FWFT).

Verification
REQ-030 BAUD_DIV=1, send 0xA5 with a valid stop bit -> rx_valid=1 and rx_data=0xA5; after rd_en, rx_valid=0.
REQ-031 RsRx low for 4 clocks, then high -> no push, no flags, FSM returns to IDLE.
REQ-032 Send 0x3C with stop=0, then hold the line low for 200 clocks -> frame_err=1 once, FIFO empty; err_clr -> frame_err=0.
REQ-033 Send 0x01..0x05 with no reads (depth 4) -> rx_full=1, overrun=1; reads return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
REQ-034 Assert RESET during bit 3 of 0xFF, release, then send 0x12 -> only 0x12 is received.
REQ-035 Loopback from the SoC UART transmitter sending 0x55 at matching baud -> rx_data=0x55 with no flags.
